pipe_csel_adder: RTL
====================

PIPE_CSEL_ADDER -- requirements
Module: pipe_csel_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 The block SHALL have parameter BLK, default 8, carry-select block width in bits.
REQ-003 The block SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 The block SHALL have a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have cin, input, 1 bit: carry-in; ignored when op_sub=1.
REQ-010 The block SHALL have op_sub, input, 1 bit: 0 selects a+b+cin, 1 selects a-b.
REQ-011 The block SHALL have out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have s, output, WIDTH bits: sum or difference.
REQ-014 The block SHALL have cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-015 The block SHALL have ov, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 WIDTH SHALL be an integer multiple of BLK, with BLK>=2; a violation SHALL be reported by an elaboration-time check.
REQ-017 Effective operand B SHALL be b when op_sub=0 and ~b when op_sub=1; effective carry-in SHALL be cin when op_sub=0 and 1 when op_sub=1.
REQ-018 Stage 1 SHALL, for every BLK slice, register both candidate sums and carries (carry-in 0 and carry-in 1), plus the block-0 sum and carry computed with the effective carry-in, and the sign bits of a and effective B.
REQ-019 Stage 2 SHALL ripple the select carry across blocks, with each block's carry-out selecting that block's candidate, and SHALL register s, cout and ov.
REQ-020 ov SHALL be (a[W-1] == effB[W-1]) && (s[W-1] != a[W-1]).
REQ-021 The latency from an accepted input to out_valid SHALL be exactly 2 cycles when out_ready=1.
REQ-022 A transfer SHALL occur on any cycle where valid&&ready are both high on the same side.
REQ-023 in_ready SHALL equal !v1 || !out_valid || out_ready, where v1 is the stage-1 valid.
REQ-024 A stage SHALL load on a transfer into it and hold its contents otherwise, so back-to-back inputs sustain 1 result per cycle.
REQ-025 While out_valid=1 and out_ready=0, s, cout and ov SHALL remain stable.
REQ-026 Simultaneous acceptance into stage 1 and drain from stage 2 in the same cycle SHALL lose no data.
REQ-027 In-flight results SHALL never be reordered or duplicated.

Reset
REQ-028 While rst_n=0, v1 and out_valid SHALL be 0, and s, cout and ov SHALL be 0.
REQ-029 in_ready SHALL be 1 from reset.
REQ-030 An assertion of reset mid-operation SHALL discard all in-flight data without emitting it.
REQ-031 The first acceptance after reset SHALL occur on the first rising edge with rst_n=1 and in_valid=1.

Structure
REQ-032 A shared package SHALL hold the default WIDTH/BLK constants and the NBLK=WIDTH/BLK derivation function.
REQ-033 One sub-module, csel_block, SHALL be instantiated NBLK times: a combinational BLK-bit adder producing sum0/c0 and sum1/c1.
REQ-034 The pipeline control SHALL reside in the top module.

Verification
REQ-035 With reset, then a=32'hFFFFFFFF, b=32'h1, cin=0, op_sub=0: s=0, cout=1, ov=0 exactly 2 cycles later.
REQ-036 With a=32'h7FFFFFFF, b=32'h1, op_sub=0: s=32'h80000000, ov=1, cout=0; with a=32'h80000000, b=1, op_sub=1: s=32'h7FFFFFFF, ov=1, cout=1.
REQ-037 With 8 back-to-back random inputs and out_ready held at 1: 8 results, in order, on consecutive cycles, matching a+effB+effcin.
REQ-038 With out_ready=0 for 5 cycles while in_valid=1: at most 2 inputs accepted, in_ready=0 afterwards, outputs stable, and all results correct after release.
REQ-039 With rst_n pulsed low while both stages are valid: out_valid=0 immediately (asynchronously), no stale result after release.
REQ-040 Re-running the random scenario with WIDTH=16, BLK=4 and with WIDTH=64, BLK=16 SHALL match the reference model.

Source files
------------

// File: rtl/pipe_csel_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
package pipe_csel_adder_pkg;

    // Default operand width and carry-select block width.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLK   = 8;

    // Operation encoding of the op_sub input.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of carry-select blocks across the operand.
    function automatic int calc_nblk(input int width, input int blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/pipe_csel_adder_csel_block.sv
// Combinational BLK-bit adder slice producing both carry-select candidates:
// one assuming a carry-in of 0 and one assuming a carry-in of 1.
module csel_block
    import pipe_csel_adder_pkg::*;
#(
    parameter int BLK = DEF_BLK
) (
    input  logic [BLK-1:0] i_a,
    input  logic [BLK-1:0] i_b,
    output logic [BLK-1:0] o_sum0,
    output logic           o_c0,
    output logic [BLK-1:0] o_sum1,
    output logic           o_c1
);

    // Candidate for a block carry-in of 0.
    assign {o_c0, o_sum0} = {1'b0, i_a} + {1'b0, i_b};

    // Candidate for a block carry-in of 1.
    assign {o_c1, o_sum1} = {1'b0, i_a} + {1'b0, i_b} + {{BLK{1'b0}}, 1'b1};

endmodule

// File: rtl/pipe_csel_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready
// handshakes on both sides.
// Stage 1 registers the per-block candidate sums/carries (block 0 already
// resolved with the effective carry-in). Stage 2 ripples the select carry
// across the blocks and registers s, cout and ov.
module pipe_csel_adder
    import pipe_csel_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ov
);

    localparam int NBLK = calc_nblk(WIDTH, BLK);

    // Reject geometries the block structure cannot represent.
    generate
        if ((BLK < 2) || ((WIDTH % BLK) != 0)) begin : g_param_check
            $error("pipe_csel_adder: WIDTH must be a multiple of BLK and BLK must be >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    logic             w_is_sub;
    logic [WIDTH-1:0] w_effb;
    logic             w_effc;

    // Subtraction is a + ~b + 1, so cin is ignored for op_sub=1.
    assign w_is_sub = (op_sub == OP_SUB);
    assign w_effb   = w_is_sub ? ~b : b;
    assign w_effc   = w_is_sub ? 1'b1 : cin;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic w_in_ready;
    logic w_in_fire;
    logic w_xfer12;

    // Stage 1 can take new data when empty, or when its content will move on.
    assign w_in_ready = !r_v1 || !r_v2 || out_ready;
    assign w_in_fire  = in_valid && w_in_ready;
    // Stage 1 content moves into stage 2 when stage 2 is empty or draining.
    assign w_xfer12   = r_v1 && (!r_v2 || out_ready);

    // ------------------------------------------------------------------
    // Candidate generation (combinational) for every block
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_sum0;
    logic [WIDTH-1:0] w_sum1;
    logic [NBLK-1:0]  w_c0;
    logic [NBLK-1:0]  w_c1;
    logic [BLK-1:0]   w_blk0_sum;
    logic             w_blk0_c;

    // Stage-1 registers shared by all blocks.
    logic [BLK-1:0]   r_blk0_sum;
    logic             r_blk0_c;
    logic             r_sign_a;
    logic             r_sign_b;

    // Stage-2 select network.
    logic [WIDTH-1:0] w_sel_sum;
    logic [NBLK:1]    w_carry;      // w_carry[k] is the carry into block k

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_blk
            csel_block #(
                .BLK(BLK)
            ) u_csel (
                .i_a    (a[gi*BLK +: BLK]),
                .i_b    (w_effb[gi*BLK +: BLK]),
                .o_sum0 (w_sum0[gi*BLK +: BLK]),
                .o_c0   (w_c0[gi]),
                .o_sum1 (w_sum1[gi*BLK +: BLK]),
                .o_c1   (w_c1[gi])
            );

            if (gi == 0) begin : g_lsb
                // Block 0 knows its carry-in already, so its result is final
                // after stage 1 and only feeds the select chain.
                assign w_sel_sum[BLK-1:0] = r_blk0_sum;
                assign w_carry[1]         = r_blk0_c;
            end else begin : g_upper
                logic [BLK-1:0] r_sum0;
                logic [BLK-1:0] r_sum1;
                logic           r_c0;
                logic           r_c1;

                // Capture both candidates of this block on an input transfer.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_sum0 <= '0;
                        r_sum1 <= '0;
                        r_c0   <= 1'b0;
                        r_c1   <= 1'b0;
                    end else if (w_in_fire) begin
                        r_sum0 <= w_sum0[gi*BLK +: BLK];
                        r_sum1 <= w_sum1[gi*BLK +: BLK];
                        r_c0   <= w_c0[gi];
                        r_c1   <= w_c1[gi];
                    end
                end

                // The incoming carry picks this block's candidate and carry-out.
                assign w_sel_sum[gi*BLK +: BLK] = w_carry[gi] ? r_sum1 : r_sum0;
                assign w_carry[gi+1]            = w_carry[gi] ? r_c1   : r_c0;
            end
        end
    endgenerate

    // Resolve block 0 with the effective carry-in before registering.
    assign w_blk0_sum = w_effc ? w_sum1[BLK-1:0] : w_sum0[BLK-1:0];
    assign w_blk0_c   = w_effc ? w_c1[0]         : w_c0[0];

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------

    // Stage-1 valid: set on accept, cleared when its content moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
        end else if (w_in_fire) begin
            r_v1 <= 1'b1;
        end else if (w_xfer12) begin
            r_v1 <= 1'b0;
        end
    end

    // Capture block 0 result and operand sign bits on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk0_sum <= '0;
            r_blk0_c   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
        end else if (w_in_fire) begin
            r_blk0_sum <= w_blk0_sum;
            r_blk0_c   <= w_blk0_c;
            r_sign_a   <= a[WIDTH-1];
            r_sign_b   <= w_effb[WIDTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ov;

    // Stage-2 valid: set when stage 1 moves in, cleared when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
        end else if (w_xfer12) begin
            r_v2 <= 1'b1;
        end else if (out_ready) begin
            r_v2 <= 1'b0;
        end
    end

    // Register the selected result; held untouched while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_ov   <= 1'b0;
        end else if (w_xfer12) begin
            r_s    <= w_sel_sum;
            r_cout <= w_carry[NBLK];
            r_ov   <= (r_sign_a == r_sign_b) && (w_sel_sum[WIDTH-1] != r_sign_a);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_v2;
    assign s         = r_s;
    assign cout      = r_cout;
    assign ov        = r_ov;

endmodule
